// File: rtl/cmp_result_counter.sv
// Comparator result counter: tallies A>B / A=B / A<B flags over a run of samples.
// Optional CMP_ONEHOT_CHECK_EN rejects non-one-hot flag samples and raises a sticky err.
//
// state  | meaning
// S_IDLE | waiting for start, counters hold
// S_RUN  | accepting valid samples
// S_DONE | run finished, counts and err frozen until start/rst
module cmp_result_counter #(
    parameter int N_SAMPLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       valid,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic [7:0] gt_cnt,
    output logic [7:0] eq_cnt,
    output logic [7:0] lt_cnt,
    output logic [7:0] samples,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gt_d, eq_d, lt_d, samples_d;
    logic       run_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

`ifdef CMP_ONEHOT_CHECK_EN
    logic err_d;
`endif

    always_comb begin
        state_d   = state_q;
        gt_d      = gt_cnt;
        eq_d      = eq_cnt;
        lt_d      = lt_cnt;
        samples_d = samples;
        run_hit   = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
        err_d     = err;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    gt_d      = 8'd0;
                    eq_d      = 8'd0;
                    lt_d      = 8'd0;
                    samples_d = 8'd0;
`ifdef CMP_ONEHOT_CHECK_EN
                    err_d     = 1'b0;
`endif
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    // restart wins over a coincident stop or sample
                    gt_d      = 8'd0;
                    eq_d      = 8'd0;
                    lt_d      = 8'd0;
                    samples_d = 8'd0;
`ifdef CMP_ONEHOT_CHECK_EN
                    err_d     = 1'b0;
`endif
                end else begin
                    if (valid) begin
                        samples_d = sat_inc(samples);
`ifdef CMP_ONEHOT_CHECK_EN
                        if ({f1, f2, f3} inside {3'b100, 3'b010, 3'b001}) begin
                            if (f1)      gt_d = sat_inc(gt_cnt);
                            else if (f2) eq_d = sat_inc(eq_cnt);
                            else         lt_d = sat_inc(lt_cnt);
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        if (f1)      gt_d = sat_inc(gt_cnt);
                        else if (f2) eq_d = sat_inc(eq_cnt);
                        else if (f3) lt_d = sat_inc(lt_cnt);
`endif
                        run_hit = (N_SAMPLES != 0) && (samples != 8'hFF)
                                  && (int'(samples_d) == N_SAMPLES);
                    end
                    if (stop || run_hit) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gt_cnt  <= 8'd0;
            eq_cnt  <= 8'd0;
            lt_cnt  <= 8'd0;
            samples <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            gt_cnt  <= gt_d;
            eq_cnt  <= eq_d;
            lt_cnt  <= lt_d;
            samples <= samples_d;
            busy    <= (state_d == S_RUN);
            done    <= (state_d == S_DONE);
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= err_d;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/cmp_result_counter.md
CMP_RESULT_COUNTER -- requirements
Module: cmp_result_counter

Interface
REQ-001 Parameter N_SAMPLES, default 16, samples per run; 0 = unlimited, run until STOP.
REQ-002 CLK  input  1  clock, all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 START  input  1  one-cycle pulse, begin a new run.
REQ-005 STOP  input  1  one-cycle pulse, end the current run early.
REQ-006 VALID  input  1  F1/F2/F3 carry a comparator result this cycle.
REQ-007 F1  input  1  comparator flag, A>B.
REQ-008 F2  input  1  comparator flag, A=B.
REQ-009 F3  input  1  comparator flag, A<B.
REQ-010 GT_CNT  output  8  count of A>B samples.
REQ-011 EQ_CNT  output  8  count of A=B samples.
REQ-012 LT_CNT  output  8  count of A<B samples.
REQ-013 SAMPLES  output  8  count of VALID samples accepted in the run.
REQ-014 BUSY  output  1  high in RUN.
REQ-015 DONE  output  1  high in DONE.
REQ-016 ERR  output  1  sticky, flags not one-hot on some accepted sample.

Function
REQ-017 FSM SHALL have states IDLE, RUN and DONE, encoded in registers, and outputs SHALL be registered.
REQ-018 In IDLE or DONE, a START pulse SHALL clear all counters and ERR, then enter RUN on the next edge.
REQ-019 In RUN, a cycle with VALID=1 SHALL increment SAMPLES and exactly one of GT_CNT/EQ_CNT/LT_CNT, selected by the high flag; the result SHALL be visible one cycle after the sampling edge.
REQ-020 In RUN, a cycle with VALID=0 SHALL leave all counters unchanged.
REQ-021 All counters SHALL saturate at 255 and SHALL never wrap.
REQ-022 RUN->DONE SHALL occur when an accepted sample makes SAMPLES equal N_SAMPLES (N_SAMPLES nonzero), or when STOP=1.
REQ-023 When STOP and VALID are high in the same cycle, that sample SHALL be counted before entering DONE.
REQ-024 STOP in IDLE or DONE SHALL be ignored.
REQ-025 When START and STOP are high in the same cycle in RUN, START SHALL take priority: counters clear and the FSM stays in RUN.
REQ-026 VALID in IDLE or DONE SHALL be ignored.
REQ-027 DONE SHALL hold all counts and ERR stable until START or RST.

Reset
REQ-028 RST=1 at a clock edge SHALL force IDLE from any state, including mid-run.
REQ-029 RST=1 SHALL zero GT_CNT, EQ_CNT, LT_CNT, SAMPLES, BUSY, DONE and ERR.
REQ-030 RST SHALL take priority over START, STOP and VALID in the same cycle.

Configuration
REQ-031 Macro CMP_ONEHOT_CHECK_EN defined: an accepted sample whose flags are not exactly one-hot SHALL set ERR, increment SAMPLES only, and leave GT/EQ/LT unchanged.
REQ-032 Macro CMP_ONEHOT_CHECK_EN undefined: ERR SHALL be tied 0, and the flags SHALL be decoded with priority F1>F2>F3, so all-zero flags increment SAMPLES only.

Verification
REQ-033 N_SAMPLES=16, START, then all 16 (A,B) 2-bit pairs with correct flags -> GT_CNT=6, EQ_CNT=4, LT_CNT=6, SAMPLES=16, DONE=1, BUSY=0, ERR=0.
REQ-034 CMP_ONEHOT_CHECK_EN defined, one sample F1=F2=1 -> ERR=1, SAMPLES=1, GT/EQ/LT=0.
REQ-035 STOP together with the 5th VALID sample -> SAMPLES=5, DONE=1 on the next cycle, and later VALID pulses produce no count change.
REQ-036 RST asserted after 7 samples of a run -> next cycle all outputs 0 and state IDLE; a following START begins a clean run.
REQ-037 N_SAMPLES=0, 300 samples with F2=1 -> EQ_CNT=255, SAMPLES=255, BUSY=1; STOP -> DONE=1.
REQ-038 START and STOP together mid-run with SAMPLES=3 -> counters 0, BUSY=1, DONE=0.
